cam_gray_stream: RTL and testbench
==================================

Name: cam_gray_stream

Overview:
- Upstream feeder of the Sobel edge stage.
- Captures an RGB565 camera byte stream (vsync/href framing, one byte per data strobe) in the system clock domain and converts each pixel to 8-bit luma.
- Emits gray pixels with x_pos/y_pos coordinates and a valid strobe, matching the Sobel input interface (320x240, x 9 bits, y 8 bits).
- Also flags frame start and frame end for downstream frame-buffer control.

Parameters:
- IMG_WIDTH, 320: active pixels per line; pixels beyond this are dropped.
- IMG_HEIGHT, 240: active lines per frame; lines beyond this are dropped.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- cam_vsync  in  1  frame sync; high = vertical blanking.
- cam_href  in  1  line valid; bytes are accepted only while high.
- cam_de  in  1  byte strobe, one clk wide per camera byte.
- cam_data  in  8  camera byte: RGB565, high byte first.
- gray_out  out  8  luma of the current pixel.
- x_pos  out  9  column of gray_out, 0..IMG_WIDTH-1.
- y_pos  out  8  row of gray_out, 0..IMG_HEIGHT-1.
- valid_out  out  1  gray_out/x_pos/y_pos valid this cycle (1-cycle pulse).
- frame_start  out  1  1-cycle pulse on the vsync falling edge that begins a frame.
- frame_done  out  1  1-cycle pulse on the vsync rising edge ending a started frame.
- overflow  out  1  sticky; set when any pixel/line is dropped for exceeding IMG_WIDTH/IMG_HEIGHT; cleared by rst or frame_start.

Behaviour:
- Reset values:
  - gray_out=0, x_pos=0, y_pos=0, valid_out=0, frame_start=0, frame_done=0, overflow=0.
  - FSM in SYNC.
- vsync/href edge detection uses one registered copy of each; edges are evaluated against the previous-cycle value.
- FSM states:
  - SYNC: ignores all bytes. On cam_vsync falling edge -> LINE_WAIT, pulse frame_start, x=y=0.
  - LINE_WAIT: href low. href high -> HI.
  - HI: cam_de & href -> latch byte as hi, -> LO.
  - LO: cam_de & href -> form pixel, -> HI.
  - href falling edge in HI or LO:
    - Discard any pending hi byte.
    - x counter <- 0.
    - If the line emitted >=1 pixel (counted or dropped), y counter +1.
    - -> LINE_WAIT.
  - vsync rising edge in any state except SYNC:
    - Pulse frame_done.
    - Discard partial pixel.
    - -> SYNC.
    - vsync has priority over a simultaneous href fall or byte.
- Pixel format:
  - hi = {R[4:0], G[5:3]}, lo = {G[2:0], B[4:0]}.
  - Expand: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
- Luma: Y = (77*R8 + 150*G8 + 29*B8) >> 8.
  - Unsigned 16-bit accumulate, no overflow possible (max 65280), truncating shift.
  - White gives 255, black gives 0.
- Latency:
  - valid_out asserts exactly 1 clk after the cycle the lo byte is sampled.
  - gray_out and coordinates are registered with it.
  - x counter increments after each emitted pixel.
- Boundaries:
  - x counter >= IMG_WIDTH: pixel not emitted, overflow set, x saturates.
  - y counter >= IMG_HEIGHT: whole line not emitted, overflow set.
  - y saturates at IMG_HEIGHT.
- cam_de while href low: ignored in every state.
- rst mid-frame:
  - All outputs return to reset values next cycle.
  - FSM waits in SYNC for the next vsync falling edge; the partial frame is never emitted.
- gray_out/x_pos/y_pos hold their last values when valid_out=0.

Optional Feature:
- Macro CAM_GRAY_TEST_PATTERN_EN.
- Defined:
  - Adds input port test_mode (1 bit).
  - When test_mode=1, gray_out = x_pos[7:0] ^ y_pos[7:0] instead of luma.
  - Framing, timing, counters and overflow are unchanged.
  - Used to check downstream edge detection against a known pattern.
- Undefined:
  - No test_mode port; luma path only.

Test Plan:
- Reset, vsync 1->0, one line of 2 pixels: 0xFFFF, 0x0000 -> frame_start pulse, then valid_out twice: (255, x=0, y=0), (0, x=1, y=0), each 1 clk after lo byte.
- Pure red 0xF800 / green 0x07E0 / blue 0x001F -> gray_out 76 / 149 / 28.
- Full 320x240 frame of 0x8410 -> 76800 valid_out pulses; last at x=319, y=239; frame_done on vsync rise; overflow=0.
- Line of 322 pixels -> pixels 320,321 not emitted, overflow=1; next line starts x=0, y+1; next frame_start clears overflow.
- href falls after a hi byte only; vsync rises mid-line -> no valid_out for the partial pixel; frame_done pulses once; FSM in SYNC ignores bytes until vsync falls.
- rst asserted at pixel (100,50) -> all outputs 0 next clk; bytes before the next vsync fall produce no valid_out; with CAM_GRAY_TEST_PATTERN_EN and test_mode=1, pixel (5,3) outputs 6.

Source files
------------

// File: rtl/cam_gray_stream_if.sv
// Camera byte stream in, gray pixel stream out, for cam_gray_stream.
// test_mode exists only when CAM_GRAY_TEST_PATTERN_EN is defined.
interface cam_gray_stream_if;
    logic       cam_vsync;
    logic       cam_href;
    logic       cam_de;
    logic [7:0] cam_data;
`ifdef CAM_GRAY_TEST_PATTERN_EN
    logic       test_mode;
`endif
    logic [7:0] gray_out;
    logic [8:0] x_pos;
    logic [7:0] y_pos;
    logic       valid_out;
    logic       frame_start;
    logic       frame_done;
    logic       overflow;

    modport master (
`ifdef CAM_GRAY_TEST_PATTERN_EN
        output test_mode,
`endif
        output cam_vsync, cam_href, cam_de, cam_data,
        input  gray_out, x_pos, y_pos, valid_out, frame_start, frame_done, overflow
    );

    modport slave (
`ifdef CAM_GRAY_TEST_PATTERN_EN
        input  test_mode,
`endif
        input  cam_vsync, cam_href, cam_de, cam_data,
        output gray_out, x_pos, y_pos, valid_out, frame_start, frame_done, overflow
    );
endinterface

// File: rtl/cam_gray_stream.sv
// RGB565 camera byte stream to 8-bit luma pixels with coordinates and frame flags.
// Optional CAM_GRAY_TEST_PATTERN_EN: test_mode replaces luma with x^y.
module cam_gray_stream #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240
) (
    input logic              clk,
    input logic              rst,
    cam_gray_stream_if.slave bus
);
    localparam logic [8:0] X_LIMIT = 9'(IMG_WIDTH);
    localparam logic [7:0] Y_LIMIT = 8'(IMG_HEIGHT);

    typedef enum logic [1:0] {
        SYNC      = 2'd0,
        LINE_WAIT = 2'd1,
        HI        = 2'd2,
        LO        = 2'd3
    } state_t;

    // Expand 5/6-bit channels by replicating MSBs, then weighted sum; max 65280 fits 16 bits.
    function automatic logic [7:0] rgb565_luma(input logic [15:0] pix);
        logic [15:0] r8;
        logic [15:0] g8;
        logic [15:0] b8;
        logic [15:0] acc;
        r8  = {8'd0, pix[15:11], pix[15:13]};
        g8  = {8'd0, pix[10:5], pix[10:9]};
        b8  = {8'd0, pix[4:0], pix[4:2]};
        acc = 16'd77 * r8 + 16'd150 * g8 + 16'd29 * b8;
        return acc[15:8];
    endfunction

    state_t     state_r;
    logic       vsync_prev_r;
    logic       href_prev_r;
    logic       line_pix_r;
    logic [7:0] hi_r;
    logic [8:0] x_cnt_r;
    logic [7:0] y_cnt_r;
    logic [7:0] gray_r;
    logic [8:0] x_pos_r;
    logic [7:0] y_pos_r;
    logic       valid_r;
    logic       frame_start_r;
    logic       frame_done_r;
    logic       overflow_r;

    logic       vsync_rise_s;
    logic       vsync_fall_s;
    logic       href_fall_s;
    logic       byte_s;
    logic       in_bounds_s;
    logic [7:0] gray_s;

    assign vsync_rise_s = bus.cam_vsync & ~vsync_prev_r;
    assign vsync_fall_s = ~bus.cam_vsync & vsync_prev_r;
    assign href_fall_s  = ~bus.cam_href & href_prev_r;
    assign byte_s       = bus.cam_de & bus.cam_href;
    assign in_bounds_s  = (x_cnt_r < X_LIMIT) && (y_cnt_r < Y_LIMIT);

    // Gray value for the pixel completed by the current lo byte.
    always_comb begin
`ifdef CAM_GRAY_TEST_PATTERN_EN
        if (bus.test_mode) begin
            gray_s = x_cnt_r[7:0] ^ y_cnt_r;
        end else begin
            gray_s = rgb565_luma({hi_r, bus.cam_data});
        end
`else
        gray_s = rgb565_luma({hi_r, bus.cam_data});
`endif
    end

    // Framing FSM, counters and registered outputs; vsync rise outranks href fall and bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= SYNC;
            vsync_prev_r  <= 1'b0;
            href_prev_r   <= 1'b0;
            line_pix_r    <= 1'b0;
            hi_r          <= 8'd0;
            x_cnt_r       <= 9'd0;
            y_cnt_r       <= 8'd0;
            gray_r        <= 8'd0;
            x_pos_r       <= 9'd0;
            y_pos_r       <= 8'd0;
            valid_r       <= 1'b0;
            frame_start_r <= 1'b0;
            frame_done_r  <= 1'b0;
            overflow_r    <= 1'b0;
        end else begin
            vsync_prev_r  <= bus.cam_vsync;
            href_prev_r   <= bus.cam_href;
            valid_r       <= 1'b0;
            frame_start_r <= 1'b0;
            frame_done_r  <= 1'b0;
            if (state_r == SYNC) begin
                if (vsync_fall_s) begin
                    state_r       <= LINE_WAIT;
                    frame_start_r <= 1'b1;
                    overflow_r    <= 1'b0;
                    x_cnt_r       <= 9'd0;
                    y_cnt_r       <= 8'd0;
                    line_pix_r    <= 1'b0;
                end
            end else if (vsync_rise_s) begin
                state_r      <= SYNC;
                frame_done_r <= 1'b1;
            end else begin
                case (state_r)
                    LINE_WAIT: begin
                        if (bus.cam_href) begin
                            state_r <= HI;
                        end
                    end
                    HI, LO: begin
                        if (href_fall_s) begin
                            state_r    <= LINE_WAIT;
                            x_cnt_r    <= 9'd0;
                            line_pix_r <= 1'b0;
                            if (line_pix_r && (y_cnt_r < Y_LIMIT)) begin
                                y_cnt_r <= y_cnt_r + 8'd1;
                            end
                        end else if (byte_s && (state_r == HI)) begin
                            hi_r    <= bus.cam_data;
                            state_r <= LO;
                        end else if (byte_s) begin
                            state_r    <= HI;
                            line_pix_r <= 1'b1;
                            if (in_bounds_s) begin
                                valid_r <= 1'b1;
                                gray_r  <= gray_s;
                                x_pos_r <= x_cnt_r;
                                y_pos_r <= y_cnt_r;
                                x_cnt_r <= x_cnt_r + 9'd1;
                            end else begin
                                overflow_r <= 1'b1;
                            end
                        end
                    end
                    default: state_r <= SYNC;
                endcase
            end
        end
    end

    assign bus.gray_out    = gray_r;
    assign bus.x_pos       = x_pos_r;
    assign bus.y_pos       = y_pos_r;
    assign bus.valid_out   = valid_r;
    assign bus.frame_start = frame_start_r;
    assign bus.frame_done  = frame_done_r;
    assign bus.overflow    = overflow_r;
endmodule

// File: tb/tb_cam_gray_stream.sv
// Randomized camera-stream bench for cam_gray_stream with a transaction-level model
// (pixel/line/frame rules) and a per-cycle compare process; small frame for run time.
module tb_cam_gray_stream;
    localparam int W = 40;
    localparam int H = 12;
    localparam int K_PIX = 0, K_FS = 1, K_FD = 2, K_OV = 3, K_RST = 4;

    typedef struct {
        int due;
        int kind;
        int gray;
        int x;
        int y;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    cam_gray_stream_if bus ();

    cam_gray_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ev_t evq[$];
    bit  in_frame = 1'b0;
    bit  line_has = 1'b0;
    int  row = 0;
    int  dut_vcount = 0;
    logic [15:0] line_q[$];

    int  hold_g = 0, hold_x = 0, hold_y = 0;
    bit  exp_v, exp_fs, exp_fd, exp_ov = 1'b0;
    ev_t e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int model_luma(input logic [15:0] p);
        int r5, g6, b5, r8, g8, b8;
        r5 = int'(p[15:11]);
        g6 = int'(p[10:5]);
        b5 = int'(p[4:0]);
        r8 = r5 * 8 + r5 / 4;
        g8 = g6 * 4 + g6 / 16;
        b8 = b5 * 8 + b5 / 4;
        return (77 * r8 + 150 * g8 + 29 * b8) / 256;
    endfunction

    function automatic int model_gray(input logic [15:0] p, input bit tm, input int x, input int y);
        if (tm) return (x ^ y) & 255;
        return model_luma(p);
    endfunction

    function automatic void push(input int kind, input int g, input int x, input int y);
        ev_t n;
        n.due = cyc + 1; n.kind = kind; n.gray = g; n.x = x; n.y = y;
        evq.push_back(n);
    endfunction

    // Per-cycle comparison of every output against the model's event stream.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            exp_v = 1'b0; exp_fs = 1'b0; exp_fd = 1'b0;
            while (evq.size() > 0 && evq[0].due <= cyc) begin
                e = evq.pop_front();
                case (e.kind)
                    K_PIX: begin exp_v = 1'b1; hold_g = e.gray; hold_x = e.x; hold_y = e.y; end
                    K_FS:  begin exp_fs = 1'b1; exp_ov = 1'b0; end
                    K_FD:  exp_fd = 1'b1;
                    K_OV:  exp_ov = 1'b1;
                    default: begin hold_g = 0; hold_x = 0; hold_y = 0; exp_ov = 1'b0; end
                endcase
            end
            if (bus.valid_out === 1'b1) dut_vcount++;
            chk("valid_out", bus.valid_out, exp_v);
            chk("gray_out", bus.gray_out, hold_g);
            chk("x_pos", bus.x_pos, hold_x);
            chk("y_pos", bus.y_pos, hold_y);
            chk("frame_start", bus.frame_start, exp_fs);
            chk("frame_done", bus.frame_done, exp_fd);
            chk("overflow", bus.overflow, exp_ov);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic put_byte(input logic [7:0] d);
        bus.cam_de = 1'b1; bus.cam_data = d;
        tick();
        bus.cam_de = 1'b0; bus.cam_data = 8'($urandom);
        idle($urandom_range(0, 2));
    endtask

    task automatic send_pixel(input logic [15:0] pix, input int k, input bit rst_here);
        bit tm;
        tm = 1'b0;
        put_byte(pix[15:8]);
`ifdef CAM_GRAY_TEST_PATTERN_EN
        tm = (k == 5 && row == 3) ? 1'b1 : 1'($urandom_range(0, 1));
        bus.test_mode = tm;
`endif
        bus.cam_de = 1'b1; bus.cam_data = pix[7:0];
        if (rst_here) begin
            rst = 1'b1;
            push(K_RST, 0, 0, 0);
            in_frame = 1'b0;
            tick();
            bus.cam_de = 1'b0;
            tick();
            rst = 1'b0;
        end else begin
            if (in_frame) begin
                line_has = 1'b1;
                if (k < W && row < H) push(K_PIX, model_gray(pix, tm, k, row), k, row);
                else push(K_OV, 0, 0, 0);
            end
            tick();
            bus.cam_de = 1'b0;
            idle($urandom_range(0, 2));
        end
    endtask

    // Sends line_q (random pixels when empty) of n pixels; hi_tail adds a lone hi byte.
    task automatic send_line(input int n, input bit hi_tail, input int rst_at);
        logic [15:0] pix;
        bus.cam_href = 1'b1;
        idle(1 + $urandom_range(0, 1));
        line_has = 1'b0;
        for (int k = 0; k < n; k++) begin
            pix = (line_q.size() > 0) ? line_q.pop_front() : 16'($urandom);
            send_pixel(pix, k, k == rst_at);
        end
        if (hi_tail) put_byte(8'($urandom));
        bus.cam_href = 1'b0;
        if (in_frame && line_has) row = (row < H) ? row + 1 : H;
        repeat (1 + $urandom_range(0, 2)) begin
            bus.cam_de = 1'($urandom_range(0, 1)); bus.cam_data = 8'($urandom);
            tick();
        end
        bus.cam_de = 1'b0;
    endtask

    task automatic frame_begin();
        bus.cam_vsync = 1'b0;
        if (!in_frame) begin
            push(K_FS, 0, 0, 0);
            in_frame = 1'b1;
            row = 0;
        end
        dut_vcount = 0;
        idle(2);
    endtask

    task automatic frame_end();
        bus.cam_vsync = 1'b1;
        if (in_frame) push(K_FD, 0, 0, 0);
        in_frame = 1'b0;
        idle(3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus.cam_vsync = 1'b1; bus.cam_href = 1'b0; bus.cam_de = 1'b0; bus.cam_data = 8'd0;
`ifdef CAM_GRAY_TEST_PATTERN_EN
        bus.test_mode = 1'b0;
`endif
        push(K_RST, 0, 0, 0);
        idle(3);
        rst = 1'b0;
        idle(3);

        chk("model_white", model_luma(16'hFFFF), 255);
        chk("model_black", model_luma(16'h0000), 0);
        chk("model_red", model_luma(16'hF800), 76);
        chk("model_green", model_luma(16'h07E0), 149);
        chk("model_blue", model_luma(16'h001F), 28);
        chk("model_mid", model_luma(16'h8410), 130);
        chk("model_tp_5_3", model_gray(16'h1234, 1'b1, 5, 3), 6);

        // Frame A: directed colours.
        frame_begin();
        line_q = '{16'hFFFF, 16'h0000};
        send_line(2, 1'b0, -1);
        line_q = '{16'hF800, 16'h07E0, 16'h001F};
        send_line(3, 1'b0, -1);
        frame_end();
        chk("frameA_pixels", dut_vcount, 5);

        // Frame B: full frame of mid gray.
        frame_begin();
        for (int l = 0; l < H; l++) begin
            for (int k = 0; k < W; k++) line_q.push_back(16'h8410);
            send_line(W, 1'b0, -1);
        end
        frame_end();
        chk("frameB_pixels", dut_vcount, W * H);
        chk("frameB_last_x", bus.x_pos, W - 1);
        chk("frameB_last_y", bus.y_pos, H - 1);
        chk("frameB_gray", bus.gray_out, 130);
        chk("frameB_overflow", bus.overflow, 0);

        // Frame C: too-long line, hi-only line, too many lines.
        frame_begin();
        send_line(W + 2, 1'b0, -1);
        send_line(3, 1'b0, -1);
        send_line(0, 1'b1, -1);
        for (int l = 0; l < H; l++) send_line(2, 1'b0, -1);
        chk("frameC_overflow", bus.overflow, 1);
        frame_end();

        // Frame D: vsync rises with a lo byte mid-line; bytes in SYNC ignored.
        frame_begin();
        send_line(2, 1'b0, -1);
        bus.cam_href = 1'b1;
        idle(1);
        send_pixel(16'($urandom), 0, 1'b0);
        put_byte(8'($urandom));
        bus.cam_de = 1'b1; bus.cam_data = 8'($urandom); bus.cam_vsync = 1'b1;
        push(K_FD, 0, 0, 0);
        in_frame = 1'b0;
        tick();
        bus.cam_de = 1'b0;
        idle(2);
        bus.cam_href = 1'b0;
        idle(2);
        send_line(4, 1'b0, -1);

        // Frame E: reset in the middle of a line, then bytes before the next vsync fall.
        frame_begin();
        for (int l = 0; l < H / 2; l++) send_line(W / 2 + 5, 1'b0, -1);
        send_line(W / 2 + 5, 1'b0, W / 2);
        send_line(5, 1'b0, -1);
        frame_end();

        // Frame F: random content (test pattern pixels when enabled).
        frame_begin();
        for (int l = 0; l < 5; l++) send_line(8 + $urandom_range(0, 4), 1'($urandom_range(0, 1)), -1);
        frame_end();
        chk("frameF_min_pixels", 32'(dut_vcount >= 40), 1);

        idle(5);
        chk("events_drained", evq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
